// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_unit                                                    |
// | Purpose  : Instruction fetch front end for the 4-cycle byte-serial imem. |
// |            Owns the PC and drives the memory address. Matches each       |
// |            imem_valid pulse to the address the memory latched, discards  |
// |            stale or overflowing responses, and queues {pc, instr} pairs  |
// |            in a small FIFO that feeds decode over valid/ready. A         |
// |            redirect flushes the FIFO and kills the in-flight fetch.      |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            imem_addr  -> memory address (combinational)                  |
// |            imem_data, imem_valid <- memory response                      |
// |            redirect_valid, redirect_pc <- branch/jump redirect           |
// |            instr_valid, instr, instr_pc -> FIFO head to decode           |
// |            instr_ready <- decode accepts head                            |
// |            fifo_count -> FIFO occupancy                                  |
// |            fetch_cnt, refetch_cnt -> statistics counters                 |
// | Options  : define FETCH_STATS_EN to build the statistics counters;       |
// |            otherwise both counter ports read as zero.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     imem_valid,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              refetch_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // PC tracking
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] npc_q, npc_d;
  logic        kill_q, kill_d;
  logic        first_q, first_d;

  // FIFO state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      pc_mem_d    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];

  logic        w_latch;
  logic        w_full;
  logic        w_live_rsp;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_tgt;

  // The memory samples imem_addr on every pulse edge and once right after reset.
  assign w_latch        = imem_valid | first_q;
  // Full uses the registered count only; a pop in the same cycle frees no slot.
  assign w_full         = (count_q == FULL_CNT);
  // A response that is not stale (not killed by an earlier redirect).
  assign w_live_rsp     = imem_valid & ~kill_q;
  assign w_push         = w_live_rsp & ~redirect_valid & ~w_full;
  assign w_pop          = instr_valid & instr_ready;
  assign w_redirect_tgt = redirect_pc & ~32'd3;

  // Address select. A live response that cannot be queued makes the memory
  // fetch the same address again so the instruction is not lost.
  always_comb begin
    imem_addr = npc_q;
    if (redirect_valid) begin
      imem_addr = w_redirect_tgt;
    end else if (w_live_rsp && w_full) begin
      imem_addr = req_pc_q;
    end
  end

  // PC / kill next state
  always_comb begin
    req_pc_d = req_pc_q;
    npc_d    = npc_q;
    kill_d   = kill_q;
    first_d  = 1'b0;
    if (w_latch) begin
      // imem_addr already carries any redirect target, so a redirect in a
      // latch cycle is taken directly by the memory and needs no kill.
      req_pc_d = imem_addr;
      npc_d    = imem_addr + 32'd4;
      kill_d   = 1'b0;
    end else if (redirect_valid) begin
      // The memory is busy on the old path; discard its next response and
      // present the target at that latch.
      npc_d  = w_redirect_tgt;
      kill_d = 1'b1;
    end
  end

  // FIFO next state
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      // Flush wins over any pop presented in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        instr_mem_d[wr_ptr_q] = imem_data;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q    <= RESET_PC;
      npc_q       <= RESET_PC;
      kill_q      <= 1'b0;
      first_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
    end else begin
      req_pc_q    <= req_pc_d;
      npc_q       <= npc_d;
      kill_q      <= kill_d;
      first_q     <= first_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign instr_valid = (count_q != '0);
  assign instr       = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign fifo_count  = count_q;

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] refetch_cnt_q, refetch_cnt_d;
  logic        w_refetch_sel;

  // Same condition that steers imem_addr to req_pc; it is always a latch.
  assign w_refetch_sel = w_live_rsp & w_full & ~redirect_valid;

  always_comb begin
    fetch_cnt_d   = fetch_cnt_q;
    refetch_cnt_d = refetch_cnt_q;
    if (w_push) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (w_latch && w_refetch_sel) begin
      refetch_cnt_d = refetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q   <= '0;
      refetch_cnt_q <= '0;
    end else begin
      fetch_cnt_q   <= fetch_cnt_d;
      refetch_cnt_q <= refetch_cnt_d;
    end
  end

  assign fetch_cnt   = fetch_cnt_q;
  assign refetch_cnt = refetch_cnt_q;
`else
  assign fetch_cnt   = '0;
  assign refetch_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                 |
// | Purpose  : Self-checking bench for fetch_unit with a 4-cycle memory      |
// |            model (data = addr ^ 0xA5A5_0000) and a queue-based           |
// |            reference model of the fetch front end.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] XOR_PAT  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  fifo_count;
  logic [31:0] fetch_cnt;
  logic [31:0] refetch_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_valid     (imem_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .fifo_count     (fifo_count),
    .fetch_cnt      (fetch_cnt),
    .refetch_cnt    (refetch_cnt)
  );

  // Memory: latches the address on the first edge after reset and on the
  // edge ending each pulse; answers four cycles after latching.
  logic [31:0] mem_addr;
  logic [1:0]  mem_wait;
  logic        mem_busy;
  logic        mem_first;

  assign imem_valid = mem_busy && (mem_wait == 2'd0);
  assign imem_data  = imem_valid ? (mem_addr ^ XOR_PAT) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 32'h0;
      mem_wait  <= 2'd0;
      mem_busy  <= 1'b0;
      mem_first <= 1'b1;
    end else if (imem_valid || mem_first) begin
      mem_addr  <= imem_addr;
      mem_wait  <= 2'd3;
      mem_busy  <= 1'b1;
      mem_first <= 1'b0;
    end else if (mem_wait != 2'd0) begin
      mem_wait <= mem_wait - 2'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain PC variables and a queue of {pc, instr}.
  logic [31:0] m_req, m_npc, m_fetch, m_refetch;
  bit          m_kill, m_first;
  logic [63:0] m_q[$];

  task automatic model_reset();
    m_req     = RESET_PC;
    m_npc     = RESET_PC;
    m_kill    = 1'b0;
    m_first   = 1'b1;
    m_fetch   = 32'h0;
    m_refetch = 32'h0;
    m_q.delete();
  endtask

  function automatic logic [31:0] model_addr();
    if (redirect_valid)
      return redirect_pc & ~32'd3;
    if (imem_valid && !m_kill && m_q.size() == DEPTH)
      return m_req;
    return m_npc;
  endfunction

  // One clock cycle: inputs are already set just after a negedge.
  task automatic tick();
    logic [31:0] a;
    logic [63:0] head;
    bit          full;
    #1;
    a = model_addr();
    chk("imem_addr", imem_addr, a);
    chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("instr_pc", instr_pc, head[63:32]);
      chk("instr", instr, head[31:0]);
    end
`ifdef FETCH_STATS_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("refetch_cnt", refetch_cnt, m_refetch);
`else
    chk("fetch_cnt", fetch_cnt, 32'h0);
    chk("refetch_cnt", refetch_cnt, 32'h0);
`endif
    full = (m_q.size() == DEPTH);
    if (redirect_valid) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
      if (imem_valid && !m_kill) begin
        if (!full) begin
          m_q.push_back({m_req, imem_data});
          m_fetch = m_fetch + 32'd1;
        end else begin
          m_refetch = m_refetch + 32'd1;
        end
      end
    end
    if (imem_valid || m_first) begin
      m_req  = a;
      m_npc  = a + 32'd4;
      m_kill = 1'b0;
    end else if (redirect_valid) begin
      m_npc  = redirect_pc & ~32'd3;
      m_kill = 1'b1;
    end
    m_first = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_addr"}, imem_addr, RESET_PC);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, "_refetch_cnt"}, refetch_cnt, 32'h0);
  endtask

  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    instr_ready    = rdy;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_imem(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (imem_valid) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, "_timeout"}, 32'(ok), 32'h1);
  endtask

  task automatic wait_head(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, "_timeout"}, 32'(ok), 32'h1);
  endtask

  task automatic wait_count(input string tag, input int n, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (32'(fifo_count) == n) begin ok = 1'b1; break; end
      tick();
    end
    chk({tag, "_timeout"}, 32'(ok), 32'h1);
  endtask

  initial begin
    int          heads;
    int          lat;
    int          cyc_prev;
    logic [31:0] exp_pc;

    rst_n          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);

    // 1: reset, first three instructions with decode always ready.
    do_reset(1'b1);
    heads    = 0;
    cyc_prev = 0;
    exp_pc   = RESET_PC;
    for (int c = 0; c < 40 && heads < 3; c++) begin
      if (instr_valid) begin
        chk("head_pc", instr_pc, exp_pc);
        chk("head_instr", instr, exp_pc ^ XOR_PAT);
        if (heads == 0) chk("first_head_cycle", 32'(c), 32'd5);
        else            chk("head_spacing", 32'(c - cyc_prev), 32'd4);
`ifdef FETCH_STATS_EN
        if (heads == 2) chk("fetch_cnt_3", fetch_cnt, 32'd3);
`endif
        cyc_prev = c;
        exp_pc   = exp_pc + 32'd4;
        heads++;
      end
      tick();
    end
    chk("phase1_heads", 32'(heads), 32'd3);

    // 2: fill the FIFO, check the refetch, then drain without gap or duplicate.
    do_reset(1'b0);
    wait_count("fill", DEPTH, 40);
    wait_imem("refetch_pulse", 10);
    #1;
    chk("refetch_addr", imem_addr, 32'h0000_0110);
    tick();
`ifdef FETCH_STATS_EN
    chk("refetch_cnt_1", refetch_cnt, 32'd1);
`endif
    instr_ready = 1'b1;
    heads  = 0;
    exp_pc = RESET_PC;
    for (int c = 0; c < 60 && heads < 6; c++) begin
      if (instr_valid) begin
        chk("drain_pc", instr_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        heads++;
      end
      tick();
    end
    chk("drain_heads", 32'(heads), 32'd6);

    // 3: redirect two cycles after a latch.
    instr_ready = 1'b0;
    wait_imem("pre_redirect", 10);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("flush_count", 32'(fifo_count), 32'h0);
    wait_imem("killed_pulse", 10);
    #1;
    chk("killed_pulse_addr", imem_addr, 32'h0000_0200);
    tick();
    instr_ready = 1'b1;
    wait_head("redir_head", 10);
    chk("redir_head_pc", instr_pc, 32'h0000_0200);

    // 4: redirect in a pulse cycle.
    wait_imem("latch_redirect", 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    #1;
    chk("latch_redir_addr", imem_addr, 32'h0000_0400);
    tick();
    redirect_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) begin lat = k + 1; break; end
      tick();
    end
    chk("latch_redir_latency", 32'(lat), 32'd5);
    chk("latch_redir_pc", instr_pc, 32'h0000_0400);

    // 5: redirect together with a pop at count 2, then back-to-back redirects.
    instr_ready = 1'b0;
    wait_count("count2", 2, 40);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_pop_count", 32'(fifo_count), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0600;
    tick();
    redirect_pc    = 32'h0000_0700;
    tick();
    redirect_valid = 1'b0;
    wait_head("b2b_head", 20);
    chk("b2b_head_pc", instr_pc, 32'h0000_0700);

    // 6: address wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_head("wrap_head0", 20);
    chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    tick();
    wait_head("wrap_head1", 20);
    chk("wrap_pc1", instr_pc, 32'h0000_0000);

    // 7: random decode back-pressure and redirects.
    for (int c = 0; c < 400; c++) begin
      instr_ready    = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc    = $urandom;
      tick();
    end

    // 8: asynchronous reset in the middle of a fetch.
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      instr_ready    = ($urandom_range(1) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
